data_memory_banked: RTL
=======================

// Module: data_memory_banked
// PURPOSE
//  Parametrised byte-addressable data memory for the MIPS datapath MEM stage; successor of the flat word memory.
//  Supports byte/half/word loads and stores, little-endian lanes, and sign/zero extension of loads.
//  Adds a valid/ready request/response handshake with configurable access latency, and alignment/range error reporting.
// PARAMETERS
//  DEPTH       256  number of 32-bit words; word index = addr[ADDR_WIDTH-1:2]
//  ADDR_WIDTH  32   byte address width
//  LATENCY     1    edges from request accept to response valid; legal 1..15
// PORTS
//  clk         in   1   single clock; all state on rising edge
//  reset       in   1   asynchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   block can accept request (IDLE only)
//  req_write   in   1   1=store, 0=load
//  req_addr    in   ADDR_WIDTH  byte address
//  req_size    in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_signed  in   1   load sign-extends when 1 (lb/lh), zero-extends when 0
//  req_wdata   in   32  store data, right-justified
//  inj_parity  in   1   store writes inverted parity (test hook; ignored without macro)
//  resp_valid  out  1   response present
//  resp_ready  in   1   consumer takes response
//  resp_rdata  out  32  load data; 0 for stores and errors
//  resp_err    out  2   00 ok, 01 misaligned/illegal size, 10 out of range, 11 parity
// BEHAVIOUR
//  Reset (reset=0, async): all memory bytes =0, FSM=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=00.
//  FSM IDLE -> WAIT -> RESP -> IDLE. Accept = req_valid & req_ready; all req_* fields latched at accept.
//  IDLE: req_ready=1. On accept: counter=LATENCY-1; next state WAIT if LATENCY>1, else access+RESP.
//  WAIT: req_ready=0; counter decrements each edge; at counter==1 the access executes, state -> RESP.
//  Access: exactly one edge per request; response fields registered on that edge.
//  RESP: resp_valid=1, outputs held stable until resp_ready=1; then IDLE. No new accept while in RESP.
//  Net latency: resp_valid high LATENCY cycles after accept edge, given resp_ready=1 back-to-back throughput = 1 req per LATENCY+1 cycles.
//  Error check priority: size 11 or misaligned (half addr[0]=1, word addr[1:0]!=0) -> 01; else index>=DEPTH -> 10.
//  Errored access: no memory write, resp_rdata=0.
//  Store lanes: byte -> lane addr[1:0] gets wdata[7:0]; half -> lanes addr[1]*2+{0,1} get wdata[15:0]; word -> all four.
//  Untouched lanes keep contents. Lane 0 = bits[7:0] (little-endian).
//  Load: selected lanes right-justified; upper bits = sign bit if req_signed else 0; word ignores req_signed.
//  Store response: resp_rdata=0, resp_err as checked.
//  Reset asserted mid-operation (WAIT/RESP): pending request dropped, no write performed if access edge not reached, memory cleared, IDLE.
//  Addresses above DEPTH never alias/wrap; they always report 10.
// CONFIGURATION
//  DMEM_PARITY_EN defined: one even-parity bit per byte stored alongside data; reset clears to 0.
//   Store writes parity of each written lane (inverted when inj_parity=1 at accept).
//   Load checks only accessed lanes; mismatch -> resp_err=11, resp_rdata still returned; errors 01/10 take priority.
//  DMEM_PARITY_EN undefined: no parity storage, inj_parity ignored, resp_err never 11.
// TESTING
//  T1 reset, then load word addr 0x0, LATENCY=1 -> resp_valid 1 cycle after accept, rdata 0x00000000, err 00.
//  T2 sw 0x8899AABB @0x10; sb 0x11 @0x11; lw @0x10 -> 0x889911BB; lb @0x13 -> 0xFFFFFF88; lbu @0x13 -> 0x00000088.
//  T3 sh 0x8001 @0x22; lh @0x22 -> 0xFFFF8001; lhu -> 0x00008001; lh @0x21 -> err 01, rdata 0, memory unchanged.
//  T4 sw @ (DEPTH*4) -> err 10, no write; following lw @0x0 -> unchanged value; size=11 @0x0 -> err 01.
//  T5 LATENCY=4, resp_ready held 0 for 3 cycles -> req_ready 0 throughout, resp held stable, IDLE the cycle after resp_ready=1.
//  T6 (DMEM_PARITY_EN) sw 0x1 @0x4 with inj_parity=1; lw @0x4 -> err 11, rdata 0x1; lb @0x5 -> err 00; reset mid-WAIT -> IDLE, resp_valid 0.

Source files
------------

// File: rtl/data_memory_banked.sv
// Byte-addressable data memory with valid/ready request/response handshake and configurable latency.
// Optional per-byte even parity is compiled in when DMEM_PARITY_EN is defined.
module data_memory_banked #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_wdata,
  input  logic                  inj_parity,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic [1:0]            resp_err
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  inj_q, inj_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic [1:0]            resp_err_q, resp_err_d;

  logic [31:0] mem_q [DEPTH];

  logic                  accept;
  logic                  access;
  logic                  a_write;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [1:0]            a_size;
  logic                  a_signed;
  logic [31:0]           a_wdata;
  logic                  a_inj;
  logic [1:0]            a_off;
  logic [IDX_W-1:0]      a_idx;
  logic [MEM_AW-1:0]     widx;
  logic                  misalign;
  logic                  out_range;
  logic [3:0]            lane_mask;
  logic [31:0]           wr_word;
  logic [31:0]           rd_word;
  logic [31:0]           rd_shift;
  logic [31:0]           load_data;
  logic                  par_bad;
  logic                  mem_we;
  logic [1:0]            acc_err;
  logic [31:0]           acc_rdata;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  assign accept = req_valid & req_ready_q;

  // With single-cycle latency the access happens on the accept edge itself, straight from the request port.
  assign access = ((state_q == ST_IDLE) && accept && (LATENCY == 1)) ||
                  ((state_q == ST_WAIT) && (cnt_q == 4'd1));

  always_comb begin
    if (state_q == ST_IDLE) begin
      a_write  = req_write;
      a_addr   = req_addr;
      a_size   = req_size;
      a_signed = req_signed;
      a_wdata  = req_wdata;
      a_inj    = inj_parity;
    end else begin
      a_write  = wr_q;
      a_addr   = addr_q;
      a_size   = size_q;
      a_signed = sgn_q;
      a_wdata  = wdata_q;
      a_inj    = inj_q;
    end
  end

  assign a_off   = a_addr[1:0];
  assign a_idx   = a_addr[ADDR_WIDTH-1:2];
  assign widx    = a_idx[MEM_AW-1:0];
  assign rd_word = mem_q[widx];

  always_comb begin
    misalign  = (a_size == 2'b11) ||
                ((a_size == 2'b01) && a_off[0]) ||
                ((a_size == 2'b10) && (a_off != 2'b00));
    out_range = (a_idx >= IDX_W'(DEPTH));
    case (a_size)
      2'b00: begin
        lane_mask = 4'b0001 << a_off;
        wr_word   = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = a_off[1] ? 4'b1100 : 4'b0011;
        wr_word   = {2{a_wdata[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        wr_word   = a_wdata;
      end
    endcase
  end

  assign rd_shift = rd_word >> {a_off, 3'b000};

  always_comb begin
    case (a_size)
      2'b00:   load_data = {{24{a_signed & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_data = {{16{a_signed & rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] par_q [DEPTH];
  logic [3:0] rd_par;
  logic [3:0] wr_par;
  logic [3:0] inj_mask;

  // Injection flips only the lowest written lane so neighbouring lanes stay checkable.
  assign inj_mask = a_inj ? (4'b0001 << a_off) : 4'b0000;
  assign rd_par   = {^rd_word[31:24], ^rd_word[23:16], ^rd_word[15:8], ^rd_word[7:0]};
  assign wr_par   = {^wr_word[31:24], ^wr_word[23:16], ^wr_word[15:8], ^wr_word[7:0]} ^ inj_mask;
  assign par_bad  = |((rd_par ^ par_q[widx]) & lane_mask);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) par_q[i] <= 4'b0000;
    end else if (mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_mask[l]) par_q[widx][l] <= wr_par[l];
      end
    end
  end
`else
  logic parity_unused;
  assign parity_unused = a_inj;
  assign par_bad       = 1'b0;
`endif

  assign mem_we = access & a_write & ~misalign & ~out_range;

  always_comb begin
    if (misalign)                  acc_err = 2'b01;
    else if (out_range)            acc_err = 2'b10;
    else if (!a_write && par_bad)  acc_err = 2'b11;
    else                           acc_err = 2'b00;
    acc_rdata = (a_write || misalign || out_range) ? 32'h0 : load_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else if (mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_mask[l]) mem_q[widx][8*l +: 8] <= wr_word[8*l +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    wdata_d      = wdata_q;
    inj_d        = inj_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wr_d        = req_write;
          addr_d      = req_addr;
          size_d      = req_size;
          sgn_d       = req_signed;
          wdata_d     = req_wdata;
          inj_d       = inj_parity;
          cnt_d       = CNT_INIT;
          req_ready_d = 1'b0;
          if (LATENCY == 1) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = acc_rdata;
            resp_err_d   = acc_err;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = acc_rdata;
          resp_err_d   = acc_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'h0;
          resp_err_d   = 2'b00;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      wdata_q      <= 32'h0;
      inj_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      wdata_q      <= wdata_d;
      inj_q        <= inj_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule
